// File: rtl/keypad_encoder_db.sv
// keypad_encoder_db: synchronised, debounced keypad encoder with a one-cycle
// keystrobe per accepted press and optional auto-repeat while a key is held.
// Snapshots with more than one key pressed encode to the all-ones ERR_CODE
// and never auto-repeat.
module keypad_encoder_db #(
  parameter int NUM_KEYS        = 13,
  parameter int CODE_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                repeat_en,
  output logic [CODE_W-1:0]   keycode,
  output logic                keystrobe,
  output logic                key_valid,
  output logic                multi_key
);

  localparam logic [CODE_W-1:0]   ERR_CODE = {CODE_W{1'b1}};
  localparam logic [NUM_KEYS-1:0] ONE_V    = NUM_KEYS'(1);
  localparam int                  CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int                  RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int                  RCNT_W   = $clog2(RMAX + 1);
  localparam logic [RCNT_W-1:0]   DELAY_V  = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0]   PERIOD_V = RCNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // True when exactly one key bit is set.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - ONE_V)) == '0);
  endfunction

  // Binary index of a one-hot snapshot; ERR_CODE for anything else.
  function automatic logic [CODE_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      code = code | (v[i] ? CODE_W'(i) : {CODE_W{1'b0}});
    end
    return is_onehot(v) ? code : ERR_CODE;
  endfunction

  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] sync_d [SYNC_STAGES];
  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                phase_q, phase_d;     // 0: waiting for first repeat, 1: periodic
  logic [CODE_W-1:0]   keycode_q, keycode_d;
  logic                keystrobe_q, keystrobe_d;
  logic                key_valid_q, key_valid_d;
  logic                multi_key_q, multi_key_d;

  logic [NUM_KEYS-1:0] sync;
  logic                sync_zero;
  logic                sync_same;
  logic [RCNT_W-1:0]   rcnt_inc;
  logic [RCNT_W-1:0]   rcnt_target;

  assign sync        = sync_q[SYNC_STAGES-1];
  assign sync_zero   = (sync == '0);
  assign sync_same   = (sync == snap_q);
  assign rcnt_inc    = rcnt_q + RCNT_W'(1);
  assign rcnt_target = phase_q ? PERIOD_V : DELAY_V;

  // Synchroniser chain: each stage takes the previous one, stage 0 takes the raw pins.
  always_comb begin
    sync_d[0] = keypad;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Next-state and output decode for the debounce / hold / release FSM.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    phase_d     = phase_q;
    keycode_d   = keycode_q;
    keystrobe_d = 1'b0;
    key_valid_d = key_valid_q;
    multi_key_d = multi_key_q;

    case (state_q)
      ST_IDLE: begin
        if (!sync_zero) begin
          snap_d  = sync;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DEBOUNCE: begin
        if (!sync_same) begin
          if (sync_zero) begin
            state_d = ST_IDLE;
          end else begin
            snap_d = sync;
            cnt_d  = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_HELD;
          keycode_d   = encode(snap_q);
          keystrobe_d = 1'b1;
          key_valid_d = 1'b1;
          multi_key_d = !is_onehot(snap_q);
          rcnt_d      = '0;
          phase_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HELD: begin
        if (sync_same) begin
          if (repeat_en && is_onehot(snap_q)) begin
            if (rcnt_inc == rcnt_target) begin
              // Guard keeps strobes from ever touching back to back.
              keystrobe_d = !keystrobe_q;
              rcnt_d      = '0;
              phase_d     = 1'b1;
            end else begin
              rcnt_d = rcnt_inc;
            end
          end else if (!repeat_en) begin
            rcnt_d  = '0;
            phase_d = 1'b0;
          end else begin
            rcnt_d = rcnt_q;
          end
        end else if (sync_zero) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          key_valid_d = 1'b0;
          keycode_d   = '0;
          multi_key_d = 1'b0;
          snap_d      = sync;
          cnt_d       = '0;
          state_d     = ST_DEBOUNCE;
        end
      end

      ST_RELEASE: begin
        if (sync_zero) begin
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_IDLE;
            keycode_d   = '0;
            key_valid_d = 1'b0;
            multi_key_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sync_same) begin
          // Release bounce: resume holding without a new strobe.
          state_d = ST_HELD;
        end else begin
          key_valid_d = 1'b0;
          keycode_d   = '0;
          multi_key_d = 1'b0;
          snap_d      = sync;
          cnt_d       = '0;
          state_d     = ST_DEBOUNCE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        keycode_d   = '0;
        key_valid_d = 1'b0;
        multi_key_d = 1'b0;
      end
    endcase
  end

  // State, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      phase_q     <= 1'b0;
      keycode_q   <= '0;
      keystrobe_q <= 1'b0;
      key_valid_q <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      phase_q     <= phase_d;
      keycode_q   <= keycode_d;
      keystrobe_q <= keystrobe_d;
      key_valid_q <= key_valid_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign keycode   = keycode_q;
  assign keystrobe = keystrobe_q;
  assign key_valid = key_valid_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_encoder_db.sv
// Directed testbench for keypad_encoder_db with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_encoder_db;

  logic        clk;
  logic        rst;
  logic [12:0] keypad;
  logic        repeat_en;
  logic [3:0]  keycode;
  logic        keystrobe;
  logic        key_valid;
  logic        multi_key;

  int total;
  int bad;
  int cyc;
  int st_cyc[$];
  logic [3:0] st_code[$];

  keypad_encoder_db dut (
    .clk       (clk),
    .rst       (rst),
    .keypad    (keypad),
    .repeat_en (repeat_en),
    .keycode   (keycode),
    .keystrobe (keystrobe),
    .key_valid (key_valid),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // Advance n falling edges, logging every strobe with its cycle number.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (keystrobe === 1'b1) begin
        st_cyc.push_back(cyc);
        st_code.push_back(keycode);
      end
    end
  endtask

  task automatic start_window();
    cyc = 0;
    st_cyc.delete();
    st_code.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; keypad = 13'h0000; repeat_en = 1'b0;
    run(3);
    total++; if (keycode !== 4'h0) begin bad++; $display("FAIL reset_keycode: got %0h expected 0", keycode); end
    total++; if (keystrobe !== 1'b0) begin bad++; $display("FAIL reset_keystrobe: got %0b expected 0", keystrobe); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid: got %0b expected 0", key_valid); end
    total++; if (multi_key !== 1'b0) begin bad++; $display("FAIL reset_multi_key: got %0b expected 0", multi_key); end
    rst = 1'b0;
    run(3);
  endtask

  task automatic test_clean_press();
    start_window();
    keypad = 13'h0008;
    run(6);
    total++; if (st_cyc.size() != 0) begin bad++; $display("FAIL press_early_strobe: got %0d strobes expected 0", st_cyc.size()); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_early_valid: got %0b expected 0", key_valid); end
    run(1);
    total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL press_strobe_at7: got %0d strobes expected 1", st_cyc.size()); end
    total++; if (keycode !== 4'd3) begin bad++; $display("FAIL press_keycode: got %0d expected 3", keycode); end
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid: got %0b expected 1", key_valid); end
    run(13);
    start_window();
    keypad = 13'h0000;
    run(6);
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL release_valid_early: got %0b expected 1", key_valid); end
    run(1);
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %0b expected 0", key_valid); end
    total++; if (keycode !== 4'd0) begin bad++; $display("FAIL release_keycode: got %0d expected 0", keycode); end
    run(10);
    total++; if (st_cyc.size() != 0) begin bad++; $display("FAIL release_strobe: got %0d strobes expected 0", st_cyc.size()); end
  endtask

  task automatic test_press_bounce();
    start_window();
    for (int i = 0; i < 10; i++) begin
      keypad = (i % 2 == 0) ? 13'h0010 : 13'h0000;
      run(1);
    end
    total++; if (st_cyc.size() != 0) begin bad++; $display("FAIL bounce_strobe: got %0d strobes expected 0", st_cyc.size()); end
    start_window();
    keypad = 13'h0010;
    run(12);
    total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL bounce_count: got %0d strobes expected 1", st_cyc.size()); end
    if (st_cyc.size() >= 1) begin
      total++; if (st_cyc[0] != 7) begin bad++; $display("FAIL bounce_latency: got cycle %0d expected 7", st_cyc[0]); end
      total++; if (st_code[0] !== 4'd4) begin bad++; $display("FAIL bounce_code: got %0d expected 4", st_code[0]); end
    end
    keypad = 13'h0000;
    run(10);
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL bounce_release: got %0b expected 0", key_valid); end
  endtask

  task automatic test_release_bounce();
    int dropped;
    start_window();
    keypad = 13'h0080;
    run(10);
    total++; if (st_cyc.size() != 1 || keycode !== 4'd7) begin bad++; $display("FAIL rbounce_accept: got %0d strobes code %0d expected 1 code 7", st_cyc.size(), keycode); end
    start_window();
    dropped = 0;
    keypad = 13'h0000;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) keypad = 13'h0080;
      run(1);
      if (key_valid !== 1'b1) dropped++;
    end
    total++; if (dropped != 0) begin bad++; $display("FAIL rbounce_valid: got %0d low cycles expected 0", dropped); end
    total++; if (st_cyc.size() != 0) begin bad++; $display("FAIL rbounce_strobe: got %0d strobes expected 0", st_cyc.size()); end
    keypad = 13'h0000;
    run(10);
    total++; if (key_valid !== 1'b0 || keycode !== 4'd0) begin bad++; $display("FAIL rbounce_release: got valid %0b code %0d expected 0 0", key_valid, keycode); end
  endtask

  task automatic test_key_change();
    start_window();
    keypad = 13'h0004;
    run(10);
    total++; if (keycode !== 4'd2) begin bad++; $display("FAIL change_first: got %0d expected 2", keycode); end
    start_window();
    keypad = 13'h0200;
    run(3);
    total++; if (key_valid !== 1'b0 || keycode !== 4'd0) begin bad++; $display("FAIL change_clear: got valid %0b code %0d expected 0 0", key_valid, keycode); end
    run(4);
    total++; if (st_cyc.size() != 1 || keycode !== 4'd9) begin bad++; $display("FAIL change_accept: got %0d strobes code %0d expected 1 code 9", st_cyc.size(), keycode); end
    if (st_cyc.size() >= 1) begin
      total++; if (st_cyc[0] != 7) begin bad++; $display("FAIL change_latency: got cycle %0d expected 7", st_cyc[0]); end
    end
    keypad = 13'h0000;
    run(10);
  endtask

  task automatic test_multi_key();
    start_window();
    keypad = 13'h0003;
    repeat_en = 1'b1;
    run(7);
    total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL multi_strobe: got %0d strobes expected 1", st_cyc.size()); end
    total++; if (keycode !== 4'hF) begin bad++; $display("FAIL multi_code: got %0h expected f", keycode); end
    total++; if (multi_key !== 1'b1) begin bad++; $display("FAIL multi_flag: got %0b expected 1", multi_key); end
    run(2000);
    total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL multi_repeat: got %0d strobes expected 1", st_cyc.size()); end
    keypad = 13'h0000;
    repeat_en = 1'b0;
    run(10);
    total++; if (multi_key !== 1'b0) begin bad++; $display("FAIL multi_clear: got %0b expected 0", multi_key); end
  endtask

  task automatic test_auto_repeat();
    int exp_a[6];
    int exp_b[3];
    exp_a = '{7, 507, 607, 707, 807, 907};
    exp_b = '{7, 507, 607};
    start_window();
    keypad = 13'h1000;
    repeat_en = 1'b1;
    run(1000);
    total++; if (st_cyc.size() != 6) begin bad++; $display("FAIL repeat_count: got %0d strobes expected 6", st_cyc.size()); end
    for (int i = 0; i < 6 && i < st_cyc.size(); i++) begin
      total++; if (st_cyc[i] != exp_a[i]) begin bad++; $display("FAIL repeat_time%0d: got cycle %0d expected %0d", i, st_cyc[i], exp_a[i]); end
      total++; if (st_code[i] !== 4'd12) begin bad++; $display("FAIL repeat_code%0d: got %0d expected 12", i, st_code[i]); end
    end
    keypad = 13'h0000;
    run(10);
    start_window();
    keypad = 13'h1000;
    run(657);
    repeat_en = 1'b0;
    run(443);
    total++; if (st_cyc.size() != 3) begin bad++; $display("FAIL repeat_off_count: got %0d strobes expected 3", st_cyc.size()); end
    for (int i = 0; i < 3 && i < st_cyc.size(); i++) begin
      total++; if (st_cyc[i] != exp_b[i]) begin bad++; $display("FAIL repeat_off_time%0d: got cycle %0d expected %0d", i, st_cyc[i], exp_b[i]); end
    end
    keypad = 13'h0000;
    run(10);
  endtask

  task automatic test_reset_mid();
    start_window();
    keypad = 13'h0020;
    run(10);
    total++; if (key_valid !== 1'b1 || keycode !== 4'd5) begin bad++; $display("FAIL rstmid_held: got valid %0b code %0d expected 1 5", key_valid, keycode); end
    rst = 1'b1;
    run(1);
    total++; if ({keycode, keystrobe, key_valid, multi_key} !== 7'd0) begin bad++; $display("FAIL rstmid_outputs: got %0h expected 0", {keycode, keystrobe, key_valid, multi_key}); end
    start_window();
    rst = 1'b0;
    run(12);
    total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL rstmid_count: got %0d strobes expected 1", st_cyc.size()); end
    if (st_cyc.size() >= 1) begin
      total++; if (st_cyc[0] != 7 || st_code[0] !== 4'd5) begin bad++; $display("FAIL rstmid_strobe: got cycle %0d code %0d expected 7 5", st_cyc[0], st_code[0]); end
    end
    keypad = 13'h0000;
    run(10);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    keypad = 13'h0000;
    repeat_en = 1'b0;
    total = 0;
    bad = 0;
    cyc = 0;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_key_change();
    test_multi_key();
    test_auto_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_encoder_db.md
Name: keypad_encoder_db

Overview:
Parametrised keypad front end that generalises the 13-key one-hot encoder.
- Synchronises a NUM_KEYS-wide raw key vector and debounces both press and release with a stable-count filter.
- Encodes the pressed key to a binary code and issues a single-cycle keystrobe per accepted press.
- Optionally emits auto-repeat strobes while a key is held.
- Feeds the game/control logic in place of the fixed-width encoder.

Parameters:
NUM_KEYS, 13, number of key inputs; must be ≤ 2**CODE_W - 1
CODE_W, 4, keycode width; all-ones code (ERR_CODE) is reserved for multi-key presses
SYNC_STAGES, 2, synchroniser flop depth (≥2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (≥1)
REPEAT_DELAY, 500, cycles in HELD before the first repeat strobe (≥1)
REPEAT_PERIOD, 100, cycles between subsequent repeat strobes (≥1)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
keypad  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
repeat_en  in  1  enables auto-repeat; synchronous level
keycode  out  CODE_W  registered code of accepted key; 0 when no key is accepted
keystrobe  out  1  registered one-cycle pulse per accepted press or repeat
key_valid  out  1  high while an accepted key is held (HELD or RELEASE)
multi_key  out  1  high while the accepted snapshot is not one-hot

Behaviour:
- Reset: rst sampled high clears synchroniser flops, snapshot, counters, state=IDLE, keycode=0, keystrobe=0, key_valid=0, multi_key=0. Reset overrides every state mid-operation; no strobe is produced on the reset edge.
- Synchroniser: SYNC_STAGES flop chain; "sync" is the last stage. All decisions use sync only.
- Encoding: one-hot snapshot bit i gives code i. A snapshot with more than one bit set gives ERR_CODE and sets multi_key.
- IDLE:
  - sync==0: stay.
  - sync≠0: snapshot<=sync, cnt<=0, go to DEBOUNCE.
- DEBOUNCE:
  - sync≠snapshot and sync==0: go to IDLE.
  - sync≠snapshot and sync≠0: snapshot<=sync, cnt<=0, stay.
  - sync==snapshot and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - sync==snapshot and cnt==DEBOUNCE_CYCLES-1: go to HELD; keycode<=encode(snapshot); keystrobe<=1 for one cycle; key_valid<=1; multi_key set per snapshot; rcnt<=0.
- HELD:
  - sync==snapshot: if repeat_en=1 and snapshot is one-hot, rcnt++. Strobe when rcnt reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles; keycode unchanged.
  - repeat_en=0 clears rcnt.
  - Multi-key snapshots never repeat.
  - sync==0: go to RELEASE, cnt<=0.
  - sync≠0 and sync≠snapshot: key_valid<=0, keycode<=0, snapshot<=sync, cnt<=0, go to DEBOUNCE. The new key strobes only after it is accepted.
- RELEASE:
  - sync==0 for DEBOUNCE_CYCLES consecutive cycles: go to IDLE; keycode<=0, key_valid<=0, multi_key<=0.
  - sync==snapshot: return to HELD with no strobe (release bounce); rcnt continues.
  - Any other nonzero sync: same as the HELD key-change path.
- Latency (defaults): keypad stable high before edge E gives keystrobe high for exactly the one cycle after edge E+6 (SYNC_STAGES + DEBOUNCE_CYCLES). No strobe on release.
- keystrobe is never high for two consecutive cycles.
- keycode is stable whenever keystrobe=1.

Test Plan:
- Clean press: keypad=13'h0008 held 20 cycles, then 0 → one keystrobe 7 edges after press, keycode=3, key_valid=1. key_valid and keycode return to 0 after release plus 6 edges. Exactly one strobe total.
- Press bounce: keypad toggles 0/13'h0010 every cycle for 10 cycles, then steady → no strobe during bouncing; one strobe with keycode=4 DEBOUNCE_CYCLES+SYNC_STAGES edges after it settles.
- Release bounce: while HELD on key 7, keypad drops to 0 for 2 cycles then returns → key_valid stays 1, no new strobe. A 10-cycle release → IDLE.
- Multi-key: keypad=13'h0003 steady → one strobe, keycode=4'hF, multi_key=1. With repeat_en=1 held 2000 cycles → no repeat strobes.
- Auto-repeat (REPEAT_DELAY=500, REPEAT_PERIOD=100): key 12 held 1000 cycles, repeat_en=1 → strobes at accept+0, +500, +600, +700, +800, +900, all keycode=12. Dropping repeat_en at +650 removes later strobes.
- Reset mid-operation: rst=1 for 1 cycle while HELD on key 5 → next cycle all outputs 0. If the key is still held, a fresh strobe follows 7 edges after rst deasserts.
